// File: rtl/serial_addsub_if.sv
// serial_addsub_if
//   Handshake and data bundle for the digit-serial adder/subtractor.
//   master : operand producer / result consumer (drives operands, in_valid, out_ready)
//   slave  : serial_addsub (drives in_ready, out_valid, result and flags)
// Signals
//   in_valid  operands and mode valid         in_ready   block can accept (IDLE only)
//   a, b      operands [WIDTH]                ci         carry-in / borrow-in
//   sub       0: a+b+ci, 1: a-b-ci            out_valid  result valid (DONE only)
//   out_ready consumer takes the result       s          result [WIDTH]
//   co        carry out of MSB                ov         signed overflow
//   z         result is zero
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;
  logic             z;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ov, z
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ov, z
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub
//   Multi-cycle digit-serial adder/subtractor. WIDTH-bit operands are processed
//   DIGIT bits per clock, N = WIDTH/DIGIT cycles per operation, with a carry
//   register between digits. Result and flags are registered on the RUN->DONE
//   edge and held until the consumer accepts them.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_addsub_if.slave (handshakes, operands, result, co/ov/z)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready high, waiting for in_valid
// RUN   | one digit per clock, counter k = 0..N-1
// DONE  | out_valid high, result/flags held until out_ready
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic            clk,
  input logic            rst_n,
  serial_addsub_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             carry_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             ov_q;
  logic             z_q;

  logic             accept;
  logic             last;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_next;
  logic             ov_dig;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (cnt == CW'(N - 1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // next-state logic; in_valid is only looked at in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.s         = s_q;
    bus.co        = co_q;
    bus.ov        = ov_q;
    bus.z         = z_q;
  end

  // Operands shift right by one digit per cycle so the current digit always
  // sits in the low bits; the sum digit enters acc from the top, so after N
  // shifts acc holds the full result in place.
  always_comb begin
    a_dig    = a_q[DIGIT-1:0];
    b_dig    = b_q[DIGIT-1:0];
    dsum     = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    acc_next = WIDTH'({dsum[DIGIT-1:0], acc} >> DIGIT);
    // carry into the digit MSB is a^b^sum at that bit; xor with carry out
    ov_dig   = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      if (accept) begin
        // subtract as a + ~b + 1; borrow-in removes the +1
        a_q     <= bus.a;
        b_q     <= bus.b ^ {WIDTH{bus.sub}};
        carry_q <= bus.ci ^ bus.sub;
        cnt     <= '0;
        acc     <= '0;
      end else if (state == RUN) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        carry_q <= dsum[DIGIT];
        acc     <= acc_next;
        if (last) begin
          s_q  <= acc_next;
          co_q <= dsum[DIGIT];
          ov_q <= ov_dig;
          z_q  <= (acc_next == '0);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         sub;
  logic         out_ready;

  int errors;
  int checks;

  serial_addsub_if #(.WIDTH(W)) bus_d2 ();
  serial_addsub_if #(.WIDTH(W)) bus_d1 ();
  serial_addsub_if #(.WIDTH(W)) bus_d8 ();

  assign bus_d2.in_valid = in_valid;   assign bus_d1.in_valid = in_valid;   assign bus_d8.in_valid = in_valid;
  assign bus_d2.a = a;                 assign bus_d1.a = a;                 assign bus_d8.a = a;
  assign bus_d2.b = b;                 assign bus_d1.b = b;                 assign bus_d8.b = b;
  assign bus_d2.ci = ci;               assign bus_d1.ci = ci;               assign bus_d8.ci = ci;
  assign bus_d2.sub = sub;             assign bus_d1.sub = sub;             assign bus_d8.sub = sub;
  assign bus_d2.out_ready = out_ready; assign bus_d1.out_ready = out_ready; assign bus_d8.out_ready = out_ready;

  serial_addsub #(.WIDTH(W), .DIGIT(2)) dut_d2 (.clk(clk), .rst_n(rst_n), .bus(bus_d2));
  serial_addsub #(.WIDTH(W), .DIGIT(1)) dut_d1 (.clk(clk), .rst_n(rst_n), .bus(bus_d1));
  serial_addsub #(.WIDTH(W), .DIGIT(8)) dut_d8 (.clk(clk), .rst_n(rst_n), .bus(bus_d8));

  // index 0: DIGIT=2, 1: DIGIT=1, 2: DIGIT=8
  logic [W-1:0] s_v [3];
  logic         co_v [3];
  logic         ov_v [3];
  logic         z_v [3];
  logic         ovld_v [3];
  logic         irdy_v [3];
  int           lat_exp [3];

  assign s_v[0] = bus_d2.s;  assign s_v[1] = bus_d1.s;  assign s_v[2] = bus_d8.s;
  assign co_v[0] = bus_d2.co; assign co_v[1] = bus_d1.co; assign co_v[2] = bus_d8.co;
  assign ov_v[0] = bus_d2.ov; assign ov_v[1] = bus_d1.ov; assign ov_v[2] = bus_d8.ov;
  assign z_v[0] = bus_d2.z;  assign z_v[1] = bus_d1.z;  assign z_v[2] = bus_d8.z;
  assign ovld_v[0] = bus_d2.out_valid; assign ovld_v[1] = bus_d1.out_valid; assign ovld_v[2] = bus_d8.out_valid;
  assign irdy_v[0] = bus_d2.in_ready;  assign irdy_v[1] = bus_d1.in_ready;  assign irdy_v[2] = bus_d8.in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_d%0d_in_ready", tag, i), 32'(irdy_v[i]), 32'd1);
      chk($sformatf("%s_d%0d_out_valid", tag, i), 32'(ovld_v[i]), 32'd0);
    end
  endtask

  // Issue one operation to all three DUTs, check latency, result, flags,
  // optionally hold out_ready low for `hold` cycles, then release.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic civ, input logic subv, input logic [W-1:0] es,
                       input logic eco, input logic eov, input logic ez, input int hold);
    int lat [3];
    bit all_seen;
    @(posedge clk); #1;
    a = av; b = bv; ci = civ; sub = subv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      all_seen = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (lat[i] == 0 && ovld_v[i] === 1'b1) lat[i] = cyc;
        if (lat[i] == 0) all_seen = 1'b0;
      end
      if (all_seen) break;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_d%0d_latency", tag, i), 32'(lat[i]), 32'(lat_exp[i]));
      chk($sformatf("%s_d%0d_s", tag, i), 32'(s_v[i]), 32'(es));
      chk($sformatf("%s_d%0d_co", tag, i), 32'(co_v[i]), 32'(eco));
      chk($sformatf("%s_d%0d_ov", tag, i), 32'(ov_v[i]), 32'(eov));
      chk($sformatf("%s_d%0d_z", tag, i), 32'(z_v[i]), 32'(ez));
      chk($sformatf("%s_d%0d_in_ready_done", tag, i), 32'(irdy_v[i]), 32'd0);
    end
    for (int h = 0; h < hold; h++) begin
      // a stray request in DONE must be ignored
      if (h == 1) begin a = 8'hAA; b = 8'h55; sub = ~subv; in_valid = 1'b1; end
      if (h == 3) begin in_valid = 1'b0; a = av; b = bv; sub = subv; end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("%s_hold%0d_d%0d_s", tag, h, i), 32'(s_v[i]), 32'(es));
        chk($sformatf("%s_hold%0d_d%0d_flags", tag, h, i),
            32'({co_v[i], ov_v[i], z_v[i]}), 32'({eco, eov, ez}));
        chk($sformatf("%s_hold%0d_d%0d_out_valid", tag, h, i), 32'(ovld_v[i]), 32'd1);
        chk($sformatf("%s_hold%0d_d%0d_in_ready", tag, h, i), 32'(irdy_v[i]), 32'd0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_all_idle({tag, "_release"});
  endtask

  task automatic model_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic civ, input logic subv);
    logic [W:0]   full;
    logic [W-1:0] bx;
    logic         eov;
    bx   = subv ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bx} + {8'd0, civ ^ subv};
    eov  = (av[W-1] == bx[W-1]) && (full[W-1] != av[W-1]);
    do_op(tag, av, bv, civ, subv, full[W-1:0], full[W], eov, full[W-1:0] == 8'd0, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    lat_exp[0] = 4; lat_exp[1] = 8; lat_exp[2] = 1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_d%0d_out_valid", i), 32'(ovld_v[i]), 32'd0);
      chk($sformatf("rst_d%0d_s", i), 32'(s_v[i]), 32'd0);
      chk($sformatf("rst_d%0d_flags", i), 32'({co_v[i], ov_v[i], z_v[i]}), 32'd0);
    end
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_idle("post_reset");

    // add cases
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);
    do_op("add_10_20_ci", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0, 0);
    // sub cases
    do_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 0);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 0);
    do_op("sub_03_03", 8'h03, 8'h03, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 0);
    do_op("sub_10_05_bi", 8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0, 1'b0, 0);
    // backpressure: 5 cycles held in DONE with a stray request
    do_op("backpressure", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 5);

    // reset two cycles into RUN
    @(posedge clk); #1;
    a = 8'h55; b = 8'h22; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrun_rst_d%0d_out_valid", i), 32'(ovld_v[i]), 32'd0);
      chk($sformatf("midrun_rst_d%0d_s", i), 32'(s_v[i]), 32'd0);
      chk($sformatf("midrun_rst_d%0d_flags", i), 32'({co_v[i], ov_v[i], z_v[i]}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_idle("midrun_release");
    do_op("after_rst", 8'h55, 8'h22, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 0);

    // random operations against a whole-word model
    for (int n = 0; n < 1000; n++) begin
      model_op($sformatf("rnd%0d", n), 8'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
